// File: rtl/tick_scheduler_if.sv
// Valid/ready event port between the tick scheduler and its consumer.
interface tick_scheduler_if;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_ready;

    modport master (output evt_valid, output evt_ch, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, output evt_ready);
endinterface

// File: rtl/tick_scheduler.sv
// Prescaler emitting a one-cycle tick enable, four periodic channel timers,
// and a round-robin serialiser presenting expirations on a valid/ready port.
module tick_scheduler #(
    parameter int unsigned FREQ_IN    = 50_000_000,
    parameter int unsigned TICK_HZ    = 10,
    parameter int unsigned FAST_COUNT = 5000,
    parameter logic [7:0]  DEF_PERIOD = 8'd10
) (
    input  logic             clkd,
    input  logic             rst_n,
    input  logic             run,
    input  logic             fast,
    input  logic [3:0]       ch_en,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_ch,
    input  logic [7:0]       cfg_period,
    output logic             tick,
    tick_scheduler_if.master evt,
    output logic [3:0]       overflow
);
    localparam int unsigned MAX_COUNT = FREQ_IN / TICK_HZ;
    localparam int unsigned TOP_COUNT = (MAX_COUNT > FAST_COUNT) ? MAX_COUNT : FAST_COUNT;
    localparam int unsigned PC_W      = (TOP_COUNT > 2) ? $clog2(TOP_COUNT) : 1;
    localparam int unsigned NCH       = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [PC_W-1:0] pc;
    logic [31:0]     term_m1;

    logic [7:0] period [NCH];
    logic [7:0] cnt    [NCH];
    logic [3:0] pend;
    logic [3:0] expire;
    logic [3:0] cfg_hit;
    logic [3:0] grant_clr;

    logic [0:0] state;
    logic [0:0] state_nx;
    logic [1:0] last;
    logic [1:0] last_nx;
    logic       evt_valid_nx;
    logic [1:0] evt_ch_nx;
    logic [1:0] sel;
    logic [1:0] idx;
    logic       sel_found;

    // Prescaler; >= lets a mid-count switch to the shorter terminal wrap at once.
    assign term_m1 = fast ? 32'(FAST_COUNT - 1) : 32'(MAX_COUNT - 1);

    always_ff @(posedge clkd) begin
        if (!rst_n) begin
            pc   <= '0;
            tick <= 1'b0;
        end else if (run) begin
            if (32'(pc) >= term_m1) begin
                pc   <= '0;
                tick <= 1'b1;
            end else begin
                pc   <= pc + PC_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // A config write outranks everything else on its channel, including expiry.
    always_comb begin
        cfg_hit = '0;
        expire  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cfg_hit[i] = cfg_we && (cfg_ch == 2'(i));
            expire[i]  = !cfg_hit[i] && ch_en[i] && tick &&
                         (period[i] != 8'd0) && (cnt[i] <= 8'd1);
        end
    end

    always_ff @(posedge clkd) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                period[i] <= DEF_PERIOD;
                cnt[i]    <= DEF_PERIOD;
            end
            pend     <= '0;
            overflow <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cfg_hit[i]) begin
                    period[i]   <= cfg_period;
                    cnt[i]      <= cfg_period;
                    overflow[i] <= 1'b0;
                end else if (!ch_en[i]) begin
                    cnt[i] <= period[i];
                end else if (tick && (period[i] != 8'd0)) begin
                    cnt[i] <= expire[i] ? period[i] : cnt[i] - 8'd1;
                end
                if (expire[i] && pend[i] && !grant_clr[i]) begin
                    overflow[i] <= 1'b1;
                end
            end
            // A same-cycle expiry re-arms the bit the grant is clearing.
            pend <= (pend & ~grant_clr) | expire;
        end
    end

    // Round-robin pick: first pending channel after the last accepted one.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = last + 2'(k);
            if (!sel_found && pend[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clkd) begin
        if (!rst_n) begin
            state         <= IDLE;
            last          <= 2'd3;
            evt.evt_valid <= 1'b0;
            evt.evt_ch    <= 2'd0;
        end else begin
            state         <= state_nx;
            last          <= last_nx;
            evt.evt_valid <= evt_valid_nx;
            evt.evt_ch    <= evt_ch_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        last_nx      = last;
        evt_valid_nx = evt.evt_valid;
        evt_ch_nx    = evt.evt_ch;
        grant_clr    = '0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nx       = OFFER;
                    evt_valid_nx   = 1'b1;
                    evt_ch_nx      = sel;
                    grant_clr[sel] = 1'b1;
                end
            end
            OFFER: begin
                if (evt.evt_ready) begin
                    state_nx     = IDLE;
                    last_nx      = evt.evt_ch;
                    evt_valid_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: accepted events are checked against a scoreboard of
// expected {channel, cycle}; per-channel period cases come from a vector table.
module tb_tick_scheduler;
    localparam int unsigned FREQ_IN    = 100;
    localparam int unsigned TICK_HZ    = 10;
    localparam int unsigned FAST_COUNT = 2;

    logic       clkd = 1'b0;
    logic       rst_n;
    logic       run;
    logic       fast;
    logic [3:0] ch_en;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period;
    logic       tick;
    logic [3:0] overflow;

    tick_scheduler_if ev();

    tick_scheduler #(
        .FREQ_IN(FREQ_IN), .TICK_HZ(TICK_HZ), .FAST_COUNT(FAST_COUNT), .DEF_PERIOD(8'd10)
    ) dut (
        .clkd(clkd), .rst_n(rst_n), .run(run), .fast(fast), .ch_en(ch_en),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .tick(tick), .evt(ev), .overflow(overflow)
    );

    always #5 clkd = ~clkd;

    typedef struct { logic [1:0] ch; int cyc; } exp_t;
    typedef struct { logic [1:0] ch; logic [7:0] period; int delay; } vec_t;

    exp_t sb[$];
    vec_t tbl[4];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   cyc   = 0;

    always @(posedge clkd) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Event monitor: pops the scoreboard on each handshake, checks offer stability on stalls.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst   = 1'b0;
    logic [1:0] prev_ch    = 2'd0;
    always @(negedge clkd) begin
        exp_t e;
        if (prev_rst && prev_valid && !prev_ready) begin
            check("stall_valid", 32'(ev.evt_valid), 32'd1);
            check("stall_ch", 32'(ev.evt_ch), 32'(prev_ch));
        end
        if (rst_n && ev.evt_valid && ev.evt_ready) begin
            n_acc++;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event at cyc %0d: got ch %0d, expected none", cyc, ev.evt_ch);
            end else begin
                e = sb.pop_front();
                if (ev.evt_ch !== e.ch || (e.cyc >= 0 && cyc != e.cyc)) begin
                    n_err++;
                    $display("FAIL event: got ch %0d at cyc %0d, expected ch %0d at cyc %0d",
                             ev.evt_ch, cyc, e.ch, e.cyc);
                end
            end
        end
        prev_valid = ev.evt_valid;
        prev_ready = ev.evt_ready;
        prev_rst   = rst_n;
        prev_ch    = ev.evt_ch;
    end

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clkd);
            #1;
        end
    endtask

    task automatic wait_tick(output int t);
        t = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clkd);
            if (tick === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_timeout at cyc %0d: got no tick, expected one within 200 cycles", cyc);
            t = cyc;
        end
    endtask

    task automatic drain(input string name, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (sb.size() == 0) break;
            @(negedge clkd);
        end
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] p);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = p;
        @(posedge clkd);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cyc %0d: got no end of test, expected $finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t1, t2, acc0;
        // {channel, period, cycles from reference tick to accepted event}
        tbl[0] = '{ch: 2'd0, period: 8'd1, delay: 12};
        tbl[1] = '{ch: 2'd2, period: 8'd3, delay: 32};
        tbl[2] = '{ch: 2'd3, period: 8'd5, delay: 52};
        tbl[3] = '{ch: 2'd1, period: 8'd2, delay: 22};

        rst_n = 1'b0; run = 1'b0; fast = 1'b0; ch_en = 4'b0000;
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_period = 8'd0; ev.evt_ready = 1'b0;
        repeat (3) @(posedge clkd);
        @(negedge clkd);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_valid", 32'(ev.evt_valid), 32'd0);
        check("rst_ch", 32'(ev.evt_ch), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clkd);
        #1;
        rst_n = 1'b1; run = 1'b1;

        // Tick spacing, then a 25-cycle freeze.
        wait_tick(t1);
        for (int k = 0; k < 3; k++) begin
            wait_tick(t2);
            check("tick_gap", 32'(t2 - t1), 32'd10);
            t1 = t2;
        end
        @(posedge clkd);
        #1;
        run = 1'b0;
        repeat (25) @(posedge clkd);
        #1;
        run = 1'b1;
        wait_tick(t2);
        check("tick_gap_frozen", 32'(t2 - t1), 32'd35);

        // Default period 10 on ch0: 10th tick after enable, then every 100 cycles.
        wait_tick(t);
        @(posedge clkd);
        #1;
        ch_en = 4'b0001; ev.evt_ready = 1'b1;
        sb.push_back('{ch: 2'd0, cyc: t + 102});
        sb.push_back('{ch: 2'd0, cyc: t + 202});
        drain("single_drain", 260);
        ch_en = 4'b0000;

        for (int v = 0; v < 4; v++) begin
            wait_tick(t);
            at_cycle(t + 1);
            ch_en = 4'b0001 << tbl[v].ch;
            sb.push_back('{ch: tbl[v].ch, cyc: t + tbl[v].delay});
            cfg_write(tbl[v].ch, tbl[v].period);
            drain("table_drain", tbl[v].delay + 20);
            ch_en = 4'b0000;
        end

        // Round robin with period 1 everywhere; last grant was ch1, so order is 2,3,0,1.
        for (int c = 0; c < 4; c++) cfg_write(2'(c), 8'd1);
        wait_tick(t);
        at_cycle(t + 1);
        ch_en = 4'b1111;
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < 4; j++)
                sb.push_back('{ch: 2'(2 + j), cyc: t + 12 + 10 * r + 2 * j});
        at_cycle(t + 29);
        check("rr_done", 32'(sb.size()), 32'd0);
        ev.evt_ready = 1'b0;
        at_cycle(t + 35);
        @(negedge clkd);
        check("bp_valid", 32'(ev.evt_valid), 32'd1);
        check("bp_ch", 32'(ev.evt_ch), 32'd2);
        at_cycle(t + 45);
        @(negedge clkd);
        check("ovf_two_ticks", 32'(overflow), 32'b1011);
        at_cycle(t + 55);
        @(negedge clkd);
        check("ovf_three_ticks", 32'(overflow), 32'b1111);
        check("bp_ch_late", 32'(ev.evt_ch), 32'd2);
        at_cycle(t + 61);
        ch_en = 4'b0000;
        // Held offer, then one coalesced event per channel.
        for (int j = 0; j < 5; j++) sb.push_back('{ch: 2'(2 + j), cyc: -1});
        ev.evt_ready = 1'b1;
        drain("release_drain", 40);
        check("ovf_sticky", 32'(overflow), 32'b1111);

        // Period 0 silences ch1 and clears its overflow.
        cfg_write(2'd1, 8'd0);
        @(negedge clkd);
        check("cfg_clears_ovf", 32'(overflow), 32'b1101);
        ch_en = 4'b0010;
        acc0 = n_acc;
        repeat (40) @(negedge clkd);
        check("period0_silent", 32'(n_acc - acc0), 32'd0);
        wait_tick(t);
        at_cycle(t + 1);
        cfg_write(2'd1, 8'd3);
        sb.push_back('{ch: 2'd1, cyc: t + 32});
        sb.push_back('{ch: 2'd1, cyc: t + 62});
        at_cycle(t + 70);
        check("tick_under_cfg", 32'(tick), 32'd1);
        // Write on a tick cycle: no decrement, so period 2 counts from the next tick.
        cfg_write(2'd1, 8'd2);
        sb.push_back('{ch: 2'd1, cyc: t + 92});
        drain("cfg_drain", 40);
        ch_en = 4'b0000;
        check("ovf_after_cfg", 32'(overflow), 32'b1101);

        // Fast mode, then a switch to fast while pc = 7.
        fast = 1'b1;
        wait_tick(t1);
        wait_tick(t2);
        check("fast_gap", 32'(t2 - t1), 32'd2);
        wait_tick(t1);
        check("fast_gap2", 32'(t1 - t2), 32'd2);
        fast = 1'b0;
        wait_tick(t);
        at_cycle(t + 7);
        fast = 1'b1;
        wait_tick(t2);
        check("fast_switch", 32'(t2 - t), 32'd8);
        wait_tick(t1);
        check("fast_after_switch", 32'(t1 - t2), 32'd2);
        fast = 1'b0;

        // Reset while ch1 is offered and ch0 is pending; last accepted was ch0.
        wait_tick(t);
        at_cycle(t + 1);
        ch_en = 4'b0011;
        sb.push_back('{ch: 2'd0, cyc: t + 12});
        at_cycle(t + 13);
        ev.evt_ready = 1'b0;
        check("pre_reset_sb", 32'(sb.size()), 32'd0);
        at_cycle(t + 25);
        @(negedge clkd);
        check("pre_reset_valid", 32'(ev.evt_valid), 32'd1);
        check("pre_reset_ch", 32'(ev.evt_ch), 32'd1);
        at_cycle(t + 26);
        rst_n = 1'b0;
        ch_en = 4'b0000;
        @(posedge clkd);
        #1;
        rst_n = 1'b1;
        @(negedge clkd);
        check("mid_rst_valid", 32'(ev.evt_valid), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        wait_tick(t);
        @(posedge clkd);
        #1;
        ch_en = 4'b0011; ev.evt_ready = 1'b1;
        sb.push_back('{ch: 2'd0, cyc: t + 102});
        sb.push_back('{ch: 2'd1, cyc: t + 104});
        drain("post_reset_drain", 150);
        ch_en = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
